// File: rtl/coeff_fetch_ctrl.sv
// Sequencer that reads DEPTH coefficient words in order and streams them with their index.
// Latency: word i valid from cycle 2+2i after start. Backpressure: holds the word and issues no read until it is accepted.
module coeff_fetch_ctrl #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              mem_read_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] READ = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   logic [1:0] state;
   logic [1:0] state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = READ;
         READ: state_nxt = HOLD;
         HOLD: if (out_ready) state_nxt = (mem_addr == LAST) ? DONE : READ;
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs are registered copies of the next-state decode, so nothing
   // downstream sees a combinational path from start or out_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         mem_read_en <= 1'b0;
         mem_addr    <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_index   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nxt;
         mem_read_en <= (state_nxt == READ);
         busy        <= (state_nxt != IDLE);
         done        <= (state_nxt == DONE);
         case (state)
            IDLE: begin
               if (start) mem_addr <= '0;
            end
            READ: begin
               // Only sample here: the memory floats its data bus outside reads.
               out_data  <= mem_data;
               out_index <= mem_addr;
               out_valid <= 1'b1;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (mem_addr != LAST) mem_addr <= mem_addr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
